// File: rtl/calc2_pkg.sv
// calc2 port driver shared definitions: command/response codes, widths,
// FSM state and the registered result record.
package calc2_pkg;

    localparam int TAG_W    = 2;
    localparam int MAX_TAGS = 4;
    localparam int CMD_W    = 4;
    localparam int DATA_W   = 32;
    localparam int RESP_W   = 2;
    localparam int CNT_W    = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2,
        RESP_TMO  = 2'd3
    } resp_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SEND_D2 = 1'b1
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [CMD_W-1:0]  cmd;
    } result_t;

endpackage

// File: rtl/calc2_port_driver_if.sv
// Client / calc2-port bundle for one port driver. The master side is the
// driver itself; the slave side is whoever feeds ops and models the port.
interface calc2_port_driver_if;
    import calc2_pkg::*;

    // client op channel
    logic              op_valid;
    logic              op_ready;
    logic [CMD_W-1:0]  op_cmd;
    logic [DATA_W-1:0] op_data1;
    logic [DATA_W-1:0] op_data2;
    logic [TAG_W-1:0]  op_tag;
    // request lines toward the calc2 port
    logic [CMD_W-1:0]  req_cmd;
    logic [DATA_W-1:0] req_data;
    logic [TAG_W-1:0]  req_tag;
    // response lines from the calc2 port
    logic [RESP_W-1:0] out_resp;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    // completed results back to the client
    logic              res_valid;
    logic [RESP_W-1:0] res_resp;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic [CMD_W-1:0]  res_cmd;
    // status
    logic [CNT_W-1:0]  outstanding;
    logic              proto_err;

    modport master (
        input  op_valid, op_cmd, op_data1, op_data2,
        input  out_resp, out_data, out_tag,
        output op_ready, op_tag,
        output req_cmd, req_data, req_tag,
        output res_valid, res_resp, res_data, res_tag, res_cmd,
        output outstanding, proto_err
    );

    modport slave (
        output op_valid, op_cmd, op_data1, op_data2,
        output out_resp, out_data, out_tag,
        input  op_ready, op_tag,
        input  req_cmd, req_data, req_tag,
        input  res_valid, res_resp, res_data, res_tag, res_cmd,
        input  outstanding, proto_err
    );

endinterface

// File: rtl/calc2_tag_scoreboard.sv
// Tag bookkeeping for the calc2 port driver: lowest-free allocation,
// per-tag busy/cmd (and age when CALC2_DRV_TIMEOUT_EN is defined),
// free-on-complete and the outstanding count.
module calc2_tag_scoreboard
    import calc2_pkg::*;
#(
    parameter int NUM_TAGS       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic              i_alloc,
    input  logic [CMD_W-1:0]  i_alloc_cmd,
    input  logic              i_rsp_vld,
    input  logic [TAG_W-1:0]  i_rsp_tag,
    output logic              o_any_free,
    output logic [TAG_W-1:0]  o_free_tag,
    output logic              o_hit,
    output logic [CMD_W-1:0]  o_hit_cmd,
    output logic              o_tmo,
    output logic [TAG_W-1:0]  o_tmo_tag,
    output logic [CMD_W-1:0]  o_tmo_cmd,
    output logic [CNT_W-1:0]  o_outstanding
);

    if (NUM_TAGS < 1 || NUM_TAGS > MAX_TAGS) begin : g_bad_num_tags
        $error("NUM_TAGS must be in 1..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [TAG_W:0] NT = NUM_TAGS[TAG_W:0];

    logic [MAX_TAGS-1:0] r_busy;
    logic [CMD_W-1:0]    r_cmd [MAX_TAGS];
    logic [CNT_W-1:0]    r_cnt;
    logic                w_free;
    logic [TAG_W-1:0]    w_free_tag;

    // lowest-numbered free tag among the configured ones
    always_comb begin
        o_any_free = 1'b0;
        o_free_tag = '0;
        for (int i = MAX_TAGS - 1; i >= 0; i--) begin
            if (i < NUM_TAGS && !r_busy[i]) begin
                o_any_free = 1'b1;
                o_free_tag = TAG_W'(i);
            end
        end
    end

    // a port response completes only a busy, in-range tag
    always_comb begin
        o_hit     = i_rsp_vld && ({1'b0, i_rsp_tag} < NT) && r_busy[i_rsp_tag];
        o_hit_cmd = r_cmd[i_rsp_tag];
    end

`ifdef CALC2_DRV_TIMEOUT_EN
    localparam int                AGE_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(TIMEOUT_CYCLES);

    logic [AGE_W-1:0] r_age [MAX_TAGS];
    logic             w_tmo_any;

    // pick the lowest expired tag; a real response owns the cycle, so the
    // timeout waits (and vanishes if that response retired the tag)
    always_comb begin
        w_tmo_any = 1'b0;
        o_tmo_tag = '0;
        for (int i = MAX_TAGS - 1; i >= 0; i--) begin
            if (i < NUM_TAGS && r_busy[i] && r_age[i] >= AGE_MAX) begin
                w_tmo_any = 1'b1;
                o_tmo_tag = TAG_W'(i);
            end
        end
        o_tmo     = w_tmo_any && !o_hit;
        o_tmo_cmd = r_cmd[o_tmo_tag];
    end

    // age counts busy cycles and saturates at the limit
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_TAGS; i++) r_age[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_TAGS; i++) begin
                if (i_alloc && o_free_tag == TAG_W'(i))
                    r_age[i] <= '0;
                else if (r_busy[i] && r_age[i] != AGE_MAX)
                    r_age[i] <= r_age[i] + AGE_W'(1);
            end
        end
    end
`else
    assign o_tmo     = 1'b0;
    assign o_tmo_tag = '0;
    assign o_tmo_cmd = '0;
`endif

    assign w_free     = o_hit || o_tmo;
    assign w_free_tag = o_hit ? i_rsp_tag : o_tmo_tag;

    // busy/cmd storage: set on allocation, cleared on completion
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
            for (int i = 0; i < MAX_TAGS; i++) r_cmd[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_TAGS; i++) begin
                if (i_alloc && o_free_tag == TAG_W'(i)) begin
                    r_busy[i] <= 1'b1;
                    r_cmd[i]  <= i_alloc_cmd;
                end else if (w_free && w_free_tag == TAG_W'(i)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // outstanding count; simultaneous alloc and free cancel out
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (i_alloc && !w_free)
            r_cnt <= r_cnt + CNT_W'(1);
        else if (!i_alloc && w_free)
            r_cnt <= r_cnt - CNT_W'(1);
    end

    assign o_outstanding = r_cnt;

endmodule

// File: rtl/calc2_port_driver.sv
// calc2 port driver: accepts client ops, sends them as a two-beat request
// (cmd+data1+tag, then data2), and matches port responses back to the
// issuing tag. Optional retire-on-timeout via CALC2_DRV_TIMEOUT_EN.
module calc2_port_driver
    import calc2_pkg::*;
#(
    parameter int NUM_TAGS       = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               c_clk,
    input  logic               reset,
    calc2_port_driver_if.master bus
);

    state_e            r_state;
    logic              r_live;
    logic [CMD_W-1:0]  r_req_cmd;
    logic [DATA_W-1:0] r_req_data;
    logic [TAG_W-1:0]  r_req_tag;
    logic [DATA_W-1:0] r_d2;
    result_t           r_res;
    logic              r_proto_err;

    logic              w_any_free;
    logic [TAG_W-1:0]  w_free_tag;
    logic              w_accept;
    logic              w_rsp_vld;
    logic              w_hit;
    logic [CMD_W-1:0]  w_hit_cmd;
    logic              w_tmo;
    logic [TAG_W-1:0]  w_tmo_tag;
    logic [CMD_W-1:0]  w_tmo_cmd;
    logic [CNT_W-1:0]  w_outstanding;

    // r_live keeps op_ready low while reset is held
    assign bus.op_ready = r_live && (r_state == ST_IDLE) && w_any_free;
    assign bus.op_tag   = w_free_tag;
    assign w_accept     = bus.op_valid && bus.op_ready;
    assign w_rsp_vld    = (bus.out_resp != RESP_NONE);

    calc2_tag_scoreboard #(
        .NUM_TAGS       (NUM_TAGS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_sb (
        .c_clk         (c_clk),
        .reset         (reset),
        .i_alloc       (w_accept),
        .i_alloc_cmd   (bus.op_cmd),
        .i_rsp_vld     (w_rsp_vld),
        .i_rsp_tag     (bus.out_tag),
        .o_any_free    (w_any_free),
        .o_free_tag    (w_free_tag),
        .o_hit         (w_hit),
        .o_hit_cmd     (w_hit_cmd),
        .o_tmo         (w_tmo),
        .o_tmo_tag     (w_tmo_tag),
        .o_tmo_cmd     (w_tmo_cmd),
        .o_outstanding (w_outstanding)
    );

    // request FSM: beat 1 carries cmd/data1/tag, beat 2 carries data2
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_live     <= 1'b0;
            r_req_cmd  <= '0;
            r_req_data <= '0;
            r_req_tag  <= '0;
            r_d2       <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req_cmd  <= bus.op_cmd;
                        r_req_data <= bus.op_data1;
                        r_req_tag  <= w_free_tag;
                        r_d2       <= bus.op_data2;
                        r_state    <= ST_SEND_D2;
                    end else begin
                        r_req_cmd  <= '0;
                        r_req_data <= '0;
                        r_req_tag  <= '0;
                    end
                end
                ST_SEND_D2: begin
                    r_req_cmd  <= CMD_NOP;
                    r_req_data <= r_d2;
                    r_req_tag  <= '0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // result register: port response first, a pending timeout otherwise
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_res <= '0;
        end else if (w_hit) begin
            r_res <= '{valid: 1'b1, resp: bus.out_resp, data: bus.out_data,
                       tag: bus.out_tag, cmd: w_hit_cmd};
        end else if (w_tmo) begin
            r_res <= '{valid: 1'b1, resp: RESP_TMO, data: '0,
                       tag: w_tmo_tag, cmd: w_tmo_cmd};
        end else begin
            r_res <= '0;
        end
    end

    // sticky protocol error: response to an idle tag, or the reserved code
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset)
            r_proto_err <= 1'b0;
        else if (w_rsp_vld && (!w_hit || bus.out_resp == RESP_TMO))
            r_proto_err <= 1'b1;
    end

    assign bus.req_cmd     = r_req_cmd;
    assign bus.req_data    = r_req_data;
    assign bus.req_tag     = r_req_tag;
    assign bus.res_valid   = r_res.valid;
    assign bus.res_resp    = r_res.resp;
    assign bus.res_data    = r_res.data;
    assign bus.res_tag     = r_res.tag;
    assign bus.res_cmd     = r_res.cmd;
    assign bus.outstanding = w_outstanding;
    assign bus.proto_err   = r_proto_err;

endmodule

// File: tb/tb_calc2_port_driver.sv
// Bench for calc2_port_driver: directed ops and port responses; expected
// results are queued at stimulus time and checked by a separate monitor.
module tb_calc2_port_driver;
    import calc2_pkg::*;

    logic c_clk = 1'b0;
    logic reset = 1'b0;
    always #5 c_clk = ~c_clk;

    calc2_port_driver_if bus();

    calc2_port_driver #(
        .NUM_TAGS       (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .c_clk (c_clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
        logic [3:0]  cmd;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic push(input logic [1:0] resp, input logic [31:0] data,
                        input logic [1:0] tag, input logic [3:0] cmd);
        exp_t e;
        e.resp = resp; e.data = data; e.tag = tag; e.cmd = cmd;
        q.push_back(e);
    endtask

    // offer one op, wait for acceptance, check both request beats
    task automatic issue(input logic [3:0] cmd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [1:0] exp_tag);
        int n;
        n = 0;
        bus.op_valid = 1'b1; bus.op_cmd = cmd; bus.op_data1 = d1; bus.op_data2 = d2;
        while (!bus.op_ready && n < 40) begin tick(); n++; end
        if (!bus.op_ready) chk("op_ready_wait", 32'(bus.op_ready), 32'd1);
        chk("op_tag", 32'(bus.op_tag), 32'(exp_tag));
        tick();
        bus.op_valid = 1'b0;
        chk("req_beat1_cmd", 32'(bus.req_cmd), 32'(cmd));
        chk("req_beat1_data", bus.req_data, d1);
        chk("req_beat1_tag", 32'(bus.req_tag), 32'(exp_tag));
        tick();
        chk("req_beat2_cmd", 32'(bus.req_cmd), 32'd0);
        chk("req_beat2_data", bus.req_data, d2);
        chk("req_beat2_tag", 32'(bus.req_tag), 32'd0);
    endtask

    task automatic respond(input logic [1:0] resp, input logic [31:0] data, input logic [1:0] tag);
        bus.out_resp = resp; bus.out_data = data; bus.out_tag = tag;
        tick();
        bus.out_resp = '0; bus.out_data = '0; bus.out_tag = '0;
    endtask

    // monitor: every res_valid must match the oldest queued expectation
    always @(negedge c_clk) begin
        if (reset && bus.res_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL res_unexpected: got tag %0d resp %0d data %0h, expected none",
                         bus.res_tag, bus.res_resp, bus.res_data);
            end else begin
                mon_e = q.pop_front();
                if (bus.res_resp !== mon_e.resp || bus.res_data !== mon_e.data ||
                    bus.res_tag !== mon_e.tag || bus.res_cmd !== mon_e.cmd) begin
                    errors++;
                    $display("FAIL res_match: got resp %0d data %0h tag %0d cmd %0d expected resp %0d data %0h tag %0d cmd %0d",
                             bus.res_resp, bus.res_data, bus.res_tag, bus.res_cmd,
                             mon_e.resp, mon_e.data, mon_e.tag, mon_e.cmd);
                end
            end
        end
    end

    initial begin
        int n;
        bus.op_valid = 1'b0; bus.op_cmd = '0; bus.op_data1 = '0; bus.op_data2 = '0;
        bus.out_resp = '0; bus.out_data = '0; bus.out_tag = '0;

        // reset state
        tick(); tick();
        chk("rst_op_ready", 32'(bus.op_ready), 32'd0);
        chk("rst_req_cmd", 32'(bus.req_cmd), 32'd0);
        chk("rst_req_data", bus.req_data, 32'd0);
        chk("rst_outstanding", 32'(bus.outstanding), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
        reset = 1'b1;
        tick();
        chk("rel_op_ready", 32'(bus.op_ready), 32'd1);

        // basic add
        issue(CMD_ADD, 32'h5, 32'h3, 2'd0);
        chk("add_outstanding", 32'(bus.outstanding), 32'd1);
        push(RESP_OK, 32'h8, 2'd0, CMD_ADD);
        respond(RESP_OK, 32'h8, 2'd0);
        chk("add_done_outstanding", 32'(bus.outstanding), 32'd0);
        chk("idle_req_cmd", 32'(bus.req_cmd), 32'd0);
        chk("idle_req_data", bus.req_data, 32'd0);

        // fill all four tags
        issue(CMD_ADD, 32'h1, 32'h2, 2'd0);
        issue(CMD_SUB, 32'h3, 32'h4, 2'd1);
        issue(CMD_SHL, 32'h5, 32'h6, 2'd2);
        issue(CMD_SHR, 32'h7, 32'h8, 2'd3);
        chk("full_outstanding", 32'(bus.outstanding), 32'd4);
        chk("full_op_ready", 32'(bus.op_ready), 32'd0);

        // free tag 2; not reusable in the response cycle itself
        push(RESP_OK, 32'h22, 2'd2, CMD_SHL);
        bus.out_resp = RESP_OK; bus.out_data = 32'h22; bus.out_tag = 2'd2;
        bus.op_valid = 1'b1; bus.op_cmd = 4'h9; bus.op_data1 = 32'hA; bus.op_data2 = 32'hB;
        chk("free_same_cycle_ready", 32'(bus.op_ready), 32'd0);
        tick();
        bus.out_resp = '0; bus.out_data = '0; bus.out_tag = '0;
        chk("free_next_ready", 32'(bus.op_ready), 32'd1);
        chk("free_next_tag", 32'(bus.op_tag), 32'd2);
        chk("free_outstanding", 32'(bus.outstanding), 32'd3);
        tick();
        bus.op_valid = 1'b0;
        chk("reuse_req_cmd", 32'(bus.req_cmd), 32'h9);
        chk("reuse_req_tag", 32'(bus.req_tag), 32'd2);
        chk("reuse_req_data", bus.req_data, 32'hA);
        chk("reuse_outstanding", 32'(bus.outstanding), 32'd4);
        tick();
        chk("reuse_req_data2", bus.req_data, 32'hB);

        // out-of-order completion, back-to-back responses
        push(RESP_OK, 32'h33, 2'd3, CMD_SHR);
        respond(RESP_OK, 32'h33, 2'd3);
        push(RESP_ERR, 32'hFFFF_FFFF, 2'd0, CMD_ADD);
        respond(RESP_ERR, 32'hFFFF_FFFF, 2'd0);
        push(RESP_OK, 32'h11, 2'd1, CMD_SUB);
        respond(RESP_OK, 32'h11, 2'd1);
        push(RESP_OK, 32'h99, 2'd2, 4'h9);
        respond(RESP_OK, 32'h99, 2'd2);
        tick();
        chk("ooo_outstanding", 32'(bus.outstanding), 32'd0);
        chk("ooo_proto_err", 32'(bus.proto_err), 32'd0);

        // response on a free tag: sticky error, no result
        respond(RESP_OK, 32'h55, 2'd1);
        chk("perr_set", 32'(bus.proto_err), 32'd1);
        chk("perr_outstanding", 32'(bus.outstanding), 32'd0);
        tick(); tick(); tick();
        chk("perr_sticky", 32'(bus.proto_err), 32'd1);

        // reset while the second beat is pending
        bus.op_valid = 1'b1; bus.op_cmd = CMD_SUB; bus.op_data1 = 32'h77; bus.op_data2 = 32'h66;
        chk("mid_op_ready", 32'(bus.op_ready), 32'd1);
        tick();
        bus.op_valid = 1'b0;
        chk("mid_beat1_cmd", 32'(bus.req_cmd), 32'(CMD_SUB));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req_cmd", 32'(bus.req_cmd), 32'd0);
        chk("mid_rst_req_data", bus.req_data, 32'd0);
        chk("mid_rst_req_tag", 32'(bus.req_tag), 32'd0);
        chk("mid_rst_outstanding", 32'(bus.outstanding), 32'd0);
        chk("mid_rst_proto_err", 32'(bus.proto_err), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("mid_rel_op_ready", 32'(bus.op_ready), 32'd1);
        chk("mid_rel_op_tag", 32'(bus.op_tag), 32'd0);

        // normal traffic after reset
        issue(CMD_SUB, 32'd10, 32'd3, 2'd0);
        push(RESP_OK, 32'd7, 2'd0, CMD_SUB);
        respond(RESP_OK, 32'd7, 2'd0);
        chk("post_outstanding", 32'(bus.outstanding), 32'd0);

`ifdef CALC2_DRV_TIMEOUT_EN
        // unanswered tag retires as a timeout; late answer flags an error
        issue(CMD_ADD, 32'h1, 32'h1, 2'd0);
        push(RESP_TMO, 32'h0, 2'd0, CMD_ADD);
        n = 0;
        while (q.size() != 0 && n < 40) begin tick(); n++; end
        chk("tmo_reported", 32'(q.size()), 32'd0);
        chk("tmo_proto_err_clear", 32'(bus.proto_err), 32'd0);
        respond(RESP_OK, 32'h5, 2'd0);
        chk("tmo_late_proto_err", 32'(bus.proto_err), 32'd1);
`endif

        n = 0;
        while (q.size() != 0 && n < 10) begin tick(); n++; end
        tick();
        chk("results_drained", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc2_port_driver.md
Name: calc2_port_driver

Overview:
- Request-side initiator for one calc2 port: accepts operations from an upstream client and drives the port's cmd/data/tag request lines.
- Allocates 2-bit tags, tracks up to 4 outstanding requests, and matches returning out_resp/out_data/out_tag back to issued operations.
- One instance per port (1-4). Used as the traffic source in unit benches and as the host-side adapter in chip-level integration.

Parameters:
- NUM_TAGS, 4, tags managed; legal range 1-4; tags 0..NUM_TAGS-1 are used.
- TIMEOUT_CYCLES, 64, cycles an outstanding tag may wait before it is retired as timed out. Used only with CALC2_DRV_TIMEOUT_EN.

Ports:
- c_clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  client offers an operation.
- op_ready  out  1  driver accepts the operation this cycle.
- op_cmd  in  [0:3]  calc2 command: 1 add, 2 sub, 5 shl, 6 shr; other values are sent unchanged.
- op_data1  in  [0:31]  operand 1.
- op_data2  in  [0:31]  operand 2 (shift amount for shifts).
- op_tag  out  [0:1]  tag assigned to the accepted operation; valid while op_valid && op_ready.
- req_cmd  out  [0:3]  to calc2 reqN_cmd_in.
- req_data  out  [0:31]  to calc2 reqN_data_in.
- req_tag  out  [0:1]  to calc2 reqN_tag_in.
- out_resp  in  [0:1]  from calc2 out_respN: 0 none, 1 success, 2 overflow/invalid, 3 reserved.
- out_data  in  [0:31]  from calc2 out_dataN.
- out_tag  in  [0:1]  from calc2 out_tagN.
- res_valid  out  1  one-cycle pulse carrying a completed result.
- res_resp  out  [0:1]  response code (3 = timeout; timeout build only).
- res_data  out  [0:31]  result data; 0 for timeout.
- res_tag  out  [0:1]  tag of the completed operation.
- res_cmd  out  [0:3]  command originally issued for that tag.
- outstanding  out  [0:2]  number of busy tags, 0-4.
- proto_err  out  1  sticky flag; set by a response on a non-busy tag or by resp 3 from the port.

Behaviour:
- Reset (asynchronous, reset=0): all outputs 0, every tag free, FSM in IDLE, proto_err cleared. Any in-flight operation is discarded and produces no res_valid.
- FSM, 2 states:
  - IDLE: op_ready = (any tag free). On op_valid && op_ready:
    - same cycle: op_tag = lowest free tag;
    - next cycle: req_cmd = op_cmd, req_data = op_data1, req_tag = op_tag; FSM moves to SEND_D2.
  - SEND_D2: op_ready = 0. Next cycle drives req_cmd = 0, req_data = latched data2, req_tag = 0; FSM returns to IDLE.
- Requests are registered (1-cycle latency). Peak issue rate is one operation per 2 cycles.
- When no operation is being sent, req_cmd, req_data and req_tag are all 0.
- Tag scoreboard: each entry holds busy, cmd and, with timeout enabled, an age counter. The busy bit is set on acceptance and cleared on completion.
- Response handling (out_resp != 0):
  - If out_tag is busy: next cycle res_valid = 1 with res_resp/res_data/res_tag copied from the port and res_cmd from the scoreboard; the tag is freed.
  - If out_tag is not busy: proto_err is set and no res_valid is produced.
  - resp 3 from the port: proto_err is set, and the result is still delivered (when the tag is busy).
- A tag freed in cycle N becomes allocatable from cycle N+1. No same-cycle reuse.
- Simultaneous allocation and completion in one cycle: outstanding is unchanged.
- Full (all NUM_TAGS busy): op_ready = 0 and the client must hold op_valid and its operands.
- outstanding is updated one cycle after acceptance or completion.
- res_valid has no backpressure. The client must sink one result per cycle.

Optional Feature:
- CALC2_DRV_TIMEOUT_EN defined:
  - each busy tag's age increments every cycle;
  - when age reaches TIMEOUT_CYCLES the driver emits res_valid with res_resp = 3, res_data = 0 and frees the tag;
  - if a real response and a timeout fall in the same cycle, the real response wins that cycle and the timeout is reported next cycle (unless that tag has just completed, in which case no timeout is reported);
  - a late response arriving after a timeout sets proto_err.
- Undefined: no age counters. Tags stay busy until the port responds; resp 3 is never synthesized.

Decomposition:
- Package calc2_pkg holds:
  - command constants CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6;
  - response constants RESP_NONE=0, RESP_OK=1, RESP_ERR=2, RESP_TMO=3;
  - the tag width constant.
- One sub-module, calc2_tag_scoreboard: lowest-free allocation, busy/cmd/age storage, free-on-complete, outstanding count. FSM and datapath stay in the top.

Test Plan:
- Basic add:
  - reset released; op add 0x00000005 + 0x00000003 accepted in cycle 0 with op_tag = 0;
  - req_cmd = 1 / data 0x5 / tag 0 in cycle 1, req_cmd = 0 / data 0x3 in cycle 2;
  - port returns resp 1, data 0x8, tag 0 → res_valid with res_data = 0x8, res_cmd = 1, res_tag = 0.
- Full:
  - 4 ops accepted back-to-back with tags 0, 1, 2, 3; outstanding = 4 and op_ready = 0;
  - response on tag 2 → next accepted op gets tag 2, no earlier than the cycle after the response.
- Out-of-order completion: responses arrive in tag order 3, 0 → res_tag order 3, 0, each carrying the matching res_cmd.
- Protocol error: out_resp = 1 on free tag 1 → proto_err = 1 and no res_valid; proto_err stays set until reset.
- Reset mid-send: reset asserted while in SEND_D2 → req_* = 0 immediately, outstanding = 0, op_ready = 1 after reset releases.
- Timeout (CALC2_DRV_TIMEOUT_EN, TIMEOUT_CYCLES = 8): no response to tag 0 → res_resp = 3, res_data = 0 after 8 cycles; a later response on tag 0 sets proto_err.
